// File: rtl/nn_pkg.sv
// Shared definitions for the NN layer generator: FSM encoding, a clog2 helper
// and the shift/ReLU/saturate activation used by every neuron node.
package nn_pkg;

    localparam int NN_STATE_W = 2;

    typedef enum logic [NN_STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } nn_state_e;

    function automatic int nn_clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Arithmetic shift, clamp negatives to 0 and positives to 2**dw-1 (dw <= 31).
    function automatic logic [31:0] sat_relu(input logic signed [63:0] acc,
                                             input int shift, input int dw);
        logic signed [63:0] s;
        logic signed [63:0] maxv;
        s    = acc >>> shift;
        maxv = (64'sd1 <<< dw) - 64'sd1;
        if (s < 0) return 32'd0;
        else if (s > maxv) return maxv[31:0];
        else return s[31:0];
    endfunction

endpackage

// File: rtl/nn_relu_sat.sv
// Combinational activation stage: scale shift, ReLU and saturation of the
// accumulator down to an unsigned DW-bit result.
module nn_relu_sat
    import nn_pkg::*;
#(
    parameter int DW    = 8,
    parameter int AW    = 23,
    parameter int SHIFT = 6
) (
    input  logic signed [AW-1:0] i_acc,
    output logic        [DW-1:0] o_data
);

    logic signed [63:0] w_acc_ext;
    logic        [31:0] w_res;

    assign w_acc_ext = {{(64-AW){i_acc[AW-1]}}, i_acc};
    assign w_res     = sat_relu(w_acc_ext, SHIFT, DW);
    // Upper bits are zero by construction; folding them in keeps any overflow saturated.
    assign o_data    = w_res[DW-1:0] | {DW{|w_res[31:DW]}};

endmodule

// File: rtl/neuron_mac_seq.sv
// Time-multiplexed fully-connected neuron: one serial MAC per input, bias add,
// then shift/ReLU/saturate. Coefficients are run-time writable while idle.
module neuron_mac_seq
    import nn_pkg::*;
#(
    parameter  int DW     = 8,
    parameter  int NUM_IN = 30,
    parameter  int SHIFT  = 6,
    localparam int AW     = 2*DW + nn_clog2(NUM_IN) + 2,
    localparam int ADW    = $clog2(NUM_IN+1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_IN*DW-1:0] in_vec,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 wr_en,
    input  logic [ADW-1:0]       wr_addr,
    input  logic [DW-1:0]        wr_data,
    output logic                 wr_err,
    output logic [DW-1:0]        out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NN_STATE_W-1:0] o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid and data are held by the sender until that edge.
    nn_state_e                r_state, w_state_nxt;
    logic [NUM_IN*DW-1:0]     r_act;
    logic signed [DW-1:0]     r_coef [NUM_IN+1];
    logic signed [AW-1:0]     r_acc, w_acc_nxt, w_prod_ext;
    logic [ADW-1:0]           r_idx;
    logic [DW-1:0]            r_out_data, w_act_out, w_cur_act;
    logic                     r_out_valid, r_wr_err;
    logic                     w_accept, w_last, w_wr_drop, w_wr_ok;
    logic signed [2*DW:0]     w_a_ext, w_w_ext, w_prod;

    assign in_ready    = (r_state == ST_IDLE) && !reset;
    assign w_accept    = in_valid && in_ready;
    assign w_last      = (r_idx == ADW'(NUM_IN-1));
    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign wr_err      = r_wr_err;
    assign o_dbg_state = r_state;

    assign w_cur_act  = r_act[r_idx*DW +: DW];
    assign w_a_ext    = {{(DW+1){1'b0}}, w_cur_act};
    assign w_w_ext    = {{(DW+1){r_coef[r_idx][DW-1]}}, r_coef[r_idx]};
    assign w_prod     = w_a_ext * w_w_ext;
    assign w_prod_ext = {{(AW-2*DW-1){w_prod[2*DW]}}, w_prod};
    assign w_acc_nxt  = r_acc + w_prod_ext;

    // Writes landing on an accept are dropped so the vector uses the old coefficients.
    assign w_wr_drop = wr_en && ((r_state != ST_IDLE) || w_accept || (wr_addr > ADW'(NUM_IN)));
    assign w_wr_ok   = wr_en && !w_wr_drop;

    nn_relu_sat #(.DW(DW), .AW(AW), .SHIFT(SHIFT)) u_relu_sat (
        .i_acc  (w_acc_nxt),
        .o_data (w_act_out)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_ACC;
            ST_ACC:  if (w_last) w_state_nxt = ST_OUT;
            ST_OUT:  if (r_out_valid && out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_act       <= '0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_wr_err    <= 1'b0;
            for (int i = 0; i <= NUM_IN; i++) r_coef[i] <= '0;
        end else begin
            r_wr_err <= w_wr_drop;
            if (w_wr_ok) r_coef[wr_addr] <= wr_data;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_act <= in_vec;
                        r_acc <= {{(AW-DW){r_coef[NUM_IN][DW-1]}}, r_coef[NUM_IN]};
                        r_idx <= '0;
                    end
                end
                ST_ACC: begin
                    r_acc <= w_acc_nxt;
                    if (w_last) begin
                        r_idx       <= '0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_act_out;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed and random checks of neuron_mac_seq: a NUM_IN=4 instance for the
// directed cases and a NUM_IN=30 instance for the random regression.
module tb_neuron_mac_seq;

    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];

    // Small instance (NUM_IN=4)
    logic          a_reset, a_in_valid, a_in_ready, a_wr_en, a_wr_err, a_out_valid, a_out_ready;
    logic [4*DW-1:0] a_in_vec;
    logic [2:0]    a_wr_addr;
    logic [7:0]    a_wr_data, a_out_data;
    logic [1:0]    a_state;
    int            a_w[4];
    int            a_bias;

    // Wide instance (NUM_IN=30)
    logic          b_reset, b_in_valid, b_in_ready, b_wr_en, b_wr_err, b_out_valid, b_out_ready;
    logic [30*DW-1:0] b_in_vec;
    logic [4:0]    b_wr_addr;
    logic [7:0]    b_wr_data, b_out_data;
    logic [1:0]    b_state;
    int            b_w[30];
    int            b_bias;

    neuron_mac_seq #(.DW(DW), .NUM_IN(4), .SHIFT(6)) dut_a (
        .clk(clk), .reset(a_reset), .in_vec(a_in_vec), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .wr_err(a_wr_err), .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .o_dbg_state(a_state)
    );

    neuron_mac_seq #(.DW(DW), .NUM_IN(30), .SHIFT(6)) dut_b (
        .clk(clk), .reset(b_reset), .in_vec(b_in_vec), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .wr_err(b_wr_err), .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .o_dbg_state(b_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_act(input longint acc);
        longint s;
        s = acc >>> 6;
        if (s < 0) return 8'd0;
        if (s > 255) return 8'd255;
        return s[7:0];
    endfunction

    function automatic logic [7:0] a_model(input logic [4*DW-1:0] v);
        longint acc;
        acc = a_bias;
        for (int i = 0; i < 4; i++) acc += longint'(v[i*8 +: 8]) * a_w[i];
        return ref_act(acc);
    endfunction

    function automatic logic [7:0] b_model(input logic [30*DW-1:0] v);
        longint acc;
        acc = b_bias;
        for (int i = 0; i < 30; i++) acc += longint'(v[i*8 +: 8]) * b_w[i];
        return ref_act(acc);
    endfunction

    // All tasks start and end just after a falling edge.
    task automatic a_write(input logic [2:0] addr, input logic [7:0] data,
                           input logic exp_err, input string tag);
        a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data;
        @(negedge clk);
        a_wr_en = 1'b0;
        chk(tag, a_wr_err, exp_err);
        if (!exp_err) begin
            if (addr == 3'd4) a_bias = int'($signed(data));
            else a_w[addr[1:0]] = int'($signed(data));
        end
    endtask

    task automatic a_send(input logic [4*DW-1:0] v, input string tag);
        int n = 0;
        while (!a_in_ready && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_in_ready"}, a_in_ready, 1'b1);
        a_in_vec = v; a_in_valid = 1'b1;
        exp_q.push_back(a_model(v));
        @(negedge clk);
        a_in_valid = 1'b0;
        a_in_vec = $urandom;
    endtask

    task automatic a_recv(input int hold, input string tag, output int lat);
        logic [7:0] held;
        lat = 1;
        while (!a_out_valid && lat < 60) begin @(negedge clk); lat++; end
        if (!a_out_valid) begin
            chk({tag, "_timeout"}, 1'b0, 1'b1);
            return;
        end
        held = a_out_data;
        a_out_ready = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, a_out_valid, 1'b1);
            chk({tag, "_hold_data"}, a_out_data, held);
            chk({tag, "_hold_in_ready"}, a_in_ready, 1'b0);
        end
        if (exp_q.size() == 0) chk({tag, "_queue_empty"}, 1'b1, 1'b0);
        else chk({tag, "_data"}, a_out_data, exp_q.pop_front());
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        chk({tag, "_valid_drop"}, a_out_valid, 1'b0);
        chk({tag, "_idle_ready"}, a_in_ready, 1'b1);
    endtask

    task automatic b_write(input logic [4:0] addr, input logic [7:0] data);
        logic exp_err;
        exp_err = (addr > 5'd30);
        b_wr_en = 1'b1; b_wr_addr = addr; b_wr_data = data;
        @(negedge clk);
        b_wr_en = 1'b0;
        chk("b_wr_err", b_wr_err, exp_err);
        if (!exp_err) begin
            if (addr == 5'd30) b_bias = int'($signed(data));
            else b_w[addr] = int'($signed(data));
        end
    endtask

    task automatic b_transact(input int hold);
        logic [30*DW-1:0] v;
        int n, lat;
        for (int i = 0; i < 30; i++) v[i*8 +: 8] = 8'($urandom_range(0, 255));
        n = 0;
        while (!b_in_ready && n < 50) begin @(negedge clk); n++; end
        b_in_vec = v; b_in_valid = 1'b1;
        exp_q.push_back(b_model(v));
        @(negedge clk);
        b_in_valid = 1'b0;
        b_in_vec = '1;
        lat = 1;
        while (!b_out_valid && lat < 80) begin @(negedge clk); lat++; end
        chk("b_latency", 64'(lat), 64'd31);
        repeat (hold) @(negedge clk);
        if (exp_q.size() == 0) chk("b_queue_empty", 1'b1, 1'b0);
        else chk("b_data", b_out_data, exp_q.pop_front());
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
    endtask

    initial begin
        int lat, seen;
        a_reset = 1'b1; a_in_valid = 1'b0; a_in_vec = '0; a_wr_en = 1'b0;
        a_wr_addr = '0; a_wr_data = '0; a_out_ready = 1'b0;
        b_reset = 1'b1; b_in_valid = 1'b0; b_in_vec = '0; b_wr_en = 1'b0;
        b_wr_addr = '0; b_wr_data = '0; b_out_ready = 1'b0;
        a_bias = 0; b_bias = 0;
        for (int i = 0; i < 4; i++) a_w[i] = 0;
        for (int i = 0; i < 30; i++) b_w[i] = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", a_in_ready, 1'b0);
        chk("rst_out_valid", a_out_valid, 1'b0);
        chk("rst_out_data", a_out_data, 8'd0);
        chk("rst_wr_err", a_wr_err, 1'b0);
        chk("rst_state", a_state, 2'd0);
        a_reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", a_in_ready, 1'b1);

        // Basic MAC: 64*(1+2+3+4) >>> 6 = 10, with latency and hold
        for (int i = 0; i < 4; i++) a_write(3'(i), 8'd64, 1'b0, "t1_wr");
        a_write(3'd4, 8'd0, 1'b0, "t1_wr_bias");
        a_send({8'd4, 8'd3, 8'd2, 8'd1}, "t1");
        a_recv(3, "t1", lat);
        chk("t1_latency", 64'(lat), 64'd5);
        chk("t1_expected_10", 64'(a_model({8'd4, 8'd3, 8'd2, 8'd1})), 64'd10);

        // Negative clamp, then positive saturation
        for (int i = 0; i < 4; i++) a_write(3'(i), 8'h80, 1'b0, "t2_wr_neg");
        a_send({4{8'd255}}, "t2_neg");
        a_recv(0, "t2_neg", lat);
        for (int i = 0; i < 4; i++) a_write(3'(i), 8'd127, 1'b0, "t2_wr_pos");
        a_send({4{8'd255}}, "t2_sat");
        a_recv(0, "t2_sat", lat);

        // Back-pressure for 10 cycles, then immediate next vector
        a_send({8'd40, 8'd30, 8'd20, 8'd10}, "t3");
        a_recv(10, "t3", lat);
        a_send({8'd1, 8'd0, 8'd0, 8'd200}, "t3_next");
        a_recv(0, "t3_next", lat);

        // Writes dropped while busy, out of range, or on an accept
        a_write(3'd0, 8'd1, 1'b0, "t4_wr"); a_write(3'd1, 8'd2, 1'b0, "t4_wr");
        a_write(3'd2, 8'd3, 1'b0, "t4_wr"); a_write(3'd3, 8'd4, 1'b0, "t4_wr");
        a_write(3'd4, 8'hFD, 1'b0, "t4_wr_bias");
        a_send({8'd5, 8'd25, 8'd50, 8'd100}, "t4");
        chk("t4_in_acc", a_state, 2'd1);
        a_write(3'd0, 8'd5, 1'b1, "t4_wr_during_acc");
        a_recv(0, "t4", lat);
        a_write(3'd7, 8'd9, 1'b1, "t4_wr_addr7");
        a_write(3'd5, 8'd9, 1'b1, "t4_wr_addr5");
        a_in_vec = {8'd5, 8'd25, 8'd50, 8'd100}; a_in_valid = 1'b1;
        a_wr_en = 1'b1; a_wr_addr = 3'd0; a_wr_data = 8'd100;
        exp_q.push_back(a_model(a_in_vec));
        @(negedge clk);
        a_in_valid = 1'b0; a_wr_en = 1'b0;
        chk("t4_wr_on_accept", a_wr_err, 1'b1);
        a_recv(0, "t4_accept_wr", lat);
        a_send({8'd5, 8'd25, 8'd50, 8'd100}, "t4_recheck");
        a_recv(0, "t4_recheck", lat);

        // Reset mid-ACC aborts and clears coefficients
        for (int i = 0; i < 4; i++) a_write(3'(i), 8'd127, 1'b0, "t5_wr");
        a_send({4{8'd255}}, "t5");
        repeat (2) @(negedge clk);
        chk("t5_acc_before_reset", a_state, 2'd1);
        a_reset = 1'b1;
        #1;
        chk("t5_in_ready_in_reset", a_in_ready, 1'b0);
        @(negedge clk);
        a_reset = 1'b0;
        exp_q.delete();
        a_bias = 0;
        for (int i = 0; i < 4; i++) a_w[i] = 0;
        seen = 0;
        repeat (10) begin
            if (a_out_valid) seen++;
            @(negedge clk);
        end
        chk("t5_no_output", 64'(seen), 64'd0);
        chk("t5_idle", a_state, 2'd0);
        a_send({8'd255, 8'd50, 8'd100, 8'd200}, "t5_zero_w");
        a_recv(0, "t5_zero_w", lat);
        a_write(3'd4, 8'd1, 1'b0, "t5_bias1");
        a_send({4{8'd0}}, "t5_bias1");
        a_recv(0, "t5_bias1", lat);
        a_write(3'd4, 8'd64, 1'b0, "t5_bias64");
        a_send({4{8'd0}}, "t5_bias64");
        a_recv(0, "t5_bias64", lat);

        // Random regression on the wide instance
        repeat (2) @(negedge clk);
        chk("b_rst_state", b_state, 2'd0);
        b_reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i <= 30; i++) b_write(5'(i), 8'($urandom_range(0, 255)));
        for (int v = 0; v < 1000; v++) begin
            if ($urandom_range(0, 7) == 0) b_write(5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            b_transact($urandom_range(0, 3));
        end
        chk("b_queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
